// File: rtl/packet_receiver_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : packet_receiver_pkg
//  Brief    : Shared flag layout, state encodings and helpers for the
//             packet_sender / packet_receiver pair.
//  Revision : 1.0  initial release
// ============================================================================
package packet_receiver_pkg;

    // Sideband flag layout carried alongside every 32-bit word
    localparam int FLAG_SOF     = 0;
    localparam int FLAG_EOF     = 1;
    localparam int FLAG_OCC_LSB = 2;
    localparam int FLAG_OCC_MSB = 3;

    localparam int WORD_W  = 32;
    localparam int FLAG_W  = 4;
    localparam int IDX_W   = 8;
    localparam int CNT_W   = 16;

    // Receiver state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } rx_state_t;

    // Occupancy of the last word; 0 means all four bytes are valid
    function automatic logic [1:0] occ_of(input logic [FLAG_W-1:0] flags);
        return flags[FLAG_OCC_MSB:FLAG_OCC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_receiver_sat_counter16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sat_counter16
//  Brief    : 16-bit up counter that adds 0..3 per cycle and sticks at
//             16'hFFFF instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  inc,
    output logic [15:0] count
);

    logic [16:0] sum;

    assign sum = {1'b0, count} + {15'd0, inc};

    // Accumulate, clamping at all-ones when the add carries out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 16'd0;
        end else if (sum[16]) begin
            count <= 16'hFFFF;
        end else begin
            count <= sum[15:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/packet_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : packet_receiver
//  Brief    : Consumes framed words from an upstream FIFO, checks that each
//             packet carries the incrementing pattern 0,1,2,... with the
//             expected length and full last word, and counts good and bad
//             packets.
//  Revision : 1.0  initial release
// ============================================================================
module packet_receiver
    import packet_receiver_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd_data_i,
    input  logic [3:0]  rd_flags_i,
    input  logic        rd_src_rdy_i,
    output logic        rd_dst_rdy_o,
    input  logic [7:0]  packet_size_i,
    input  logic        stall_i,
    output logic        pkt_done_o,
    output logic        pkt_ok_o,
    output logic [15:0] pkt_count_o,
    output logic [15:0] err_count_o
);

    rx_state_t   state;
    rx_state_t   next_state;

    logic [7:0]  word_idx;
    logic [7:0]  size_q;
    logic        bad;

    // A second close queued behind the one being reported this cycle
    logic        pend_valid;
    logic        pend_ok;

    logic        xfer;
    logic        sof;
    logic        eof;
    logic [1:0]  occ;
    logic        data_match;
    logic        start_ok;
    logic        recv_ok;

    logic        first_valid;
    logic        first_ok;
    logic        second_valid;
    logic        second_ok;
    logic        framing_err;

    logic        emit_valid;
    logic        emit_ok;
    logic        store_valid;
    logic        store_ok;

    logic [1:0]  good_inc;
    logic [1:0]  err_inc;

    assign rd_dst_rdy_o = reset & ~stall_i;
    assign xfer         = rd_src_rdy_i & rd_dst_rdy_o;
    assign sof          = rd_flags_i[FLAG_SOF];
    assign eof          = rd_flags_i[FLAG_EOF];
    assign occ          = occ_of(rd_flags_i);
    assign data_match   = (rd_data_i == {24'd0, word_idx});

    // A packet that opens and ends on the same word: pattern word 0, length 1
    assign start_ok = (rd_data_i == 32'd0) && (packet_size_i == 8'd1) && (occ == 2'd0);

    // Final word of a packet in progress; index 255 means a 256th word
    assign recv_ok  = ~bad && data_match && (word_idx != 8'hFF)
                      && ((word_idx + 8'd1) == size_q) && (occ == 2'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; only accepted words move the machine
    always_comb begin
        next_state = state;
        if (xfer) begin
            case (state)
                ST_IDLE: begin
                    if (eof)      next_state = ST_IDLE;
                    else if (sof) next_state = ST_RECV;
                    else          next_state = ST_DROP;
                end
                ST_RECV: begin
                    if (eof)      next_state = ST_IDLE;
                    else          next_state = ST_RECV;
                end
                ST_DROP: begin
                    if (eof)      next_state = ST_IDLE;
                    else if (sof) next_state = ST_RECV;
                    else          next_state = ST_DROP;
                end
                default:          next_state = ST_IDLE;
            endcase
        end
    end

    // Close and error decode for the word being accepted this cycle
    always_comb begin
        first_valid  = 1'b0;
        first_ok     = 1'b0;
        second_valid = 1'b0;
        second_ok    = 1'b0;
        framing_err  = 1'b0;
        if (xfer) begin
            case (state)
                ST_IDLE: begin
                    if (sof && eof) begin
                        first_valid = 1'b1;
                        first_ok    = start_ok;
                    end else if (!sof) begin
                        framing_err = 1'b1;
                    end
                end
                ST_RECV: begin
                    if (sof) begin
                        // Interrupted packet is bad; a SOF+EOF word then
                        // closes its own one-word packet one cycle later
                        first_valid  = 1'b1;
                        first_ok     = 1'b0;
                        second_valid = eof;
                        second_ok    = start_ok;
                    end else if (eof) begin
                        first_valid = 1'b1;
                        first_ok    = recv_ok;
                    end
                end
                ST_DROP: begin
                    if (sof && eof) begin
                        first_valid = 1'b1;
                        first_ok    = start_ok;
                    end
                end
                default: ;
            endcase
        end

        // Only one close is reported per cycle; a queued one goes first
        if (pend_valid) begin
            emit_valid  = 1'b1;
            emit_ok     = pend_ok;
            store_valid = first_valid;
            store_ok    = first_ok;
        end else begin
            emit_valid  = first_valid;
            emit_ok     = first_ok;
            store_valid = second_valid;
            store_ok    = second_ok;
        end

        good_inc = {1'b0, emit_valid & emit_ok};
        err_inc  = {1'b0, emit_valid & ~emit_ok} + {1'b0, framing_err};
    end

    // Packet tracking registers and close reporting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx   <= 8'd0;
            size_q     <= 8'd0;
            bad        <= 1'b0;
            pend_valid <= 1'b0;
            pend_ok    <= 1'b0;
            pkt_done_o <= 1'b0;
            pkt_ok_o   <= 1'b0;
        end else begin
            pkt_done_o <= emit_valid;
            if (emit_valid) begin
                pkt_ok_o <= emit_ok;
            end
            pend_valid <= store_valid;
            pend_ok    <= store_ok;

            if (xfer) begin
                if (sof) begin
                    word_idx <= 8'd1;
                    size_q   <= packet_size_i;
                    bad      <= (rd_data_i != 32'd0);
                end else if (state == ST_RECV) begin
                    word_idx <= word_idx + 8'd1;
                    bad      <= bad | ~data_match | (word_idx == 8'hFF);
                end
            end
        end
    end

    sat_counter16 u_pkt_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (good_inc),
        .count (pkt_count_o)
    );

    sat_counter16 u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .count (err_count_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_packet_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_packet_receiver
//  Brief    : Directed self-checking bench for packet_receiver with a verdict
//             scoreboard fed by the stimulus and drained on pkt_done_o.
//  Revision : 1.0  initial release
// ============================================================================
module tb_packet_receiver;

    logic        clk;
    logic        reset;
    logic [31:0] rd_data_i;
    logic [3:0]  rd_flags_i;
    logic        rd_src_rdy_i;
    logic        rd_dst_rdy_o;
    logic [7:0]  packet_size_i;
    logic        stall_i;
    logic        pkt_done_o;
    logic        pkt_ok_o;
    logic [15:0] pkt_count_o;
    logic [15:0] err_count_o;

    int errors  = 0;
    int checks  = 0;
    int exp_pkt = 0;
    int exp_err = 0;
    bit exp_q[$];

    packet_receiver dut (
        .clk           (clk),
        .reset         (reset),
        .rd_data_i     (rd_data_i),
        .rd_flags_i    (rd_flags_i),
        .rd_src_rdy_i  (rd_src_rdy_i),
        .rd_dst_rdy_o  (rd_dst_rdy_o),
        .packet_size_i (packet_size_i),
        .stall_i       (stall_i),
        .pkt_done_o    (pkt_done_o),
        .pkt_ok_o      (pkt_ok_o),
        .pkt_count_o   (pkt_count_o),
        .err_count_o   (err_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard drain: every close pulse must match the oldest verdict
    always @(negedge clk) begin
        if (reset === 1'b1 && pkt_done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {31'd0, pkt_done_o}, 32'd0);
            end else begin
                bit e;
                e = exp_q.pop_front();
                chk("pkt_ok", {31'd0, pkt_ok_o}, {31'd0, e});
            end
        end
    end

    // Present one word for one cycle (stall assumed low)
    task automatic send_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] o);
        rd_data_i    = d;
        rd_flags_i   = {o, e, s};
        rd_src_rdy_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_src_rdy_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pattern packet 0..n-1; optional corrupted word, last-word occupancy
    // and a 10-cycle stall before word index stall_at
    task automatic send_pkt(input int n, input int size, input int corrupt,
                            input logic [1:0] occ, input int stall_at);
        logic [31:0] d;
        bit          ok;
        packet_size_i = size[7:0];
        for (int i = 0; i < n; i++) begin
            d = (i == corrupt) ? 32'hDEAD : 32'(i);
            if (i == stall_at) begin
                rd_data_i    = d;
                rd_flags_i   = 4'd0;
                rd_src_rdy_i = 1'b1;
                stall_i      = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("stall_rdy", {31'd0, rd_dst_rdy_o}, 32'd0);
                end
                @(posedge clk);
                #1;
                stall_i = 1'b0;
            end
            if (i == n - 1) begin
                ok = (corrupt < 0) && (n == size) && (occ == 2'd0) && (n <= 255);
                exp_q.push_back(ok);
                if (ok) exp_pkt++;
                else    exp_err++;
            end
            send_word(d, i == 0, i == n - 1, (i == n - 1) ? occ : 2'd0);
        end
    endtask

    task automatic check_counts(input string tag);
        idle(3);
        chk({tag, "_pkt"}, {16'd0, pkt_count_o}, 32'(exp_pkt));
        chk({tag, "_err"}, {16'd0, err_count_o}, 32'(exp_err));
    endtask

    initial begin
        reset         = 1'b0;
        stall_i       = 1'b0;
        rd_src_rdy_i  = 1'b0;
        rd_data_i     = 32'd0;
        rd_flags_i    = 4'd0;
        packet_size_i = 8'd16;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy",  {31'd0, rd_dst_rdy_o}, 32'd0);
        chk("rst_done", {31'd0, pkt_done_o},   32'd0);
        chk("rst_ok",   {31'd0, pkt_ok_o},     32'd0);
        chk("rst_pkt",  {16'd0, pkt_count_o},  32'd0);
        chk("rst_err",  {16'd0, err_count_o},  32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", {31'd0, rd_dst_rdy_o}, 32'd1);

        // Clean 16-word packet
        send_pkt(16, 16, -1, 2'd0, -1);
        check_counts("good16");
        chk("ok_held",   {31'd0, pkt_ok_o},   32'd1);
        chk("done_pulse", {31'd0, pkt_done_o}, 32'd0);

        // Same packet with back-pressure after word 5
        send_pkt(16, 16, -1, 2'd0, 5);
        check_counts("stall");

        // Word 7 corrupted
        send_pkt(16, 16, 6, 2'd0, -1);
        check_counts("corrupt");

        // Short packet, then a partial last word
        send_pkt(12, 16, -1, 2'd0, -1);
        check_counts("short");
        send_pkt(16, 16, -1, 2'd2, -1);
        check_counts("occ2");

        // Three words without SOF, then a good packet
        packet_size_i = 8'd16;
        exp_err++;
        for (int i = 0; i < 3; i++) send_word(32'h55 + 32'(i), 1'b0, 1'b0, 2'd0);
        check_counts("nosof");
        send_pkt(16, 16, -1, 2'd0, -1);
        check_counts("after_drop");

        // Lone EOF word without SOF stays idle and counts one error
        exp_err++;
        send_word(32'h9, 1'b0, 1'b1, 2'd0);
        send_pkt(4, 4, -1, 2'd0, -1);
        check_counts("lone_eof");

        // SOF arriving as word 8 interrupts the first packet
        packet_size_i = 8'd16;
        for (int i = 0; i < 7; i++) send_word(32'(i), i == 0, 1'b0, 2'd0);
        exp_q.push_back(1'b0);
        exp_err++;
        send_pkt(16, 16, -1, 2'd0, -1);
        check_counts("resof");

        // One-word packet, and one that interrupts a packet in progress
        send_pkt(1, 1, -1, 2'd0, -1);
        check_counts("one_word");
        packet_size_i = 8'd16;
        for (int i = 0; i < 4; i++) send_word(32'(i), i == 0, 1'b0, 2'd0);
        exp_q.push_back(1'b0);
        exp_err++;
        send_pkt(1, 1, -1, 2'd0, -1);
        check_counts("resof_eof");

        // Length limits: 255 words fits, 256 words does not
        send_pkt(255, 255, -1, 2'd0, -1);
        check_counts("len255");
        send_pkt(256, 0, -1, 2'd0, -1);
        check_counts("len256");

        // Reset mid-packet clears everything immediately
        packet_size_i = 8'd16;
        for (int i = 0; i < 6; i++) send_word(32'(i), i == 0, 1'b0, 2'd0);
        rd_src_rdy_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_rdy", {31'd0, rd_dst_rdy_o}, 32'd0);
        chk("mid_rst_ok",  {31'd0, pkt_ok_o},     32'd0);
        chk("mid_rst_pkt", {16'd0, pkt_count_o},  32'd0);
        chk("mid_rst_err", {16'd0, err_count_o},  32'd0);
        exp_q.delete();
        exp_pkt = 0;
        exp_err = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(16, 16, -1, 2'd0, -1);
        check_counts("post_rst");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have rd_data_i  input  32  word from the upstream FIFO read side.
REQ-004 SHALL have rd_flags_i  input  4  bit0 SOF, bit1 EOF, bits[3:2] occupancy of the last word (0 = all 4 bytes valid).
REQ-005 SHALL have rd_src_rdy_i  input  1  upstream has a valid word.
REQ-006 SHALL have rd_dst_rdy_o  output  1  receiver accepts a word; transfer = rd_src_rdy_i & rd_dst_rdy_o at the clock edge.
REQ-007 SHALL have packet_size_i  input  8  expected packet length in words, sampled at SOF.
REQ-008 SHALL have stall_i  input  1  when 1, deasserts rd_dst_rdy_o to emulate back-pressure.
REQ-009 SHALL have pkt_done_o  output  1  one-cycle pulse when a packet closes.
REQ-010 SHALL have pkt_ok_o  output  1  verdict of the last closed packet, valid with pkt_done_o and held until the next close.
REQ-011 SHALL have pkt_count_o  output  16  count of good packets.
REQ-012 SHALL have err_count_o  output  16  count of bad packets and framing errors.

Function
REQ-013 SHALL drive rd_dst_rdy_o = ~stall_i while out of reset, combinationally with no added latency.
REQ-014 SHALL implement the states IDLE, RECV and DROP.
REQ-015 IDLE: a transfer with SOF SHALL set word_idx=1, latch packet_size_i, set bad = (data != 0), and enter RECV; if that word also has EOF, it SHALL close immediately as a 1-word packet.
REQ-016 IDLE: a transfer without SOF SHALL increment err_count_o and enter DROP; if the word has EOF, it SHALL stay in IDLE.
REQ-017 RECV: each transfer SHALL compare rd_data_i against the zero-extended word_idx, set bad on mismatch, and increment word_idx (8-bit, wraps at 255).
REQ-018 RECV: a transfer with EOF SHALL close the packet; ok = ~bad & (words received == latched size) & (occupancy == 0); then go to IDLE.
REQ-019 RECV: a transfer with SOF but no EOF SHALL close the current packet as bad and restart as REQ-015 with this word; SOF+EOF SHALL do the same, then close the new 1-word packet on the next cycle.
REQ-020 RECV: a packet longer than 255 words SHALL be marked bad.
REQ-021 DROP: SHALL discard words until an EOF transfer, then go to IDLE; a SOF in DROP SHALL restart as REQ-015.
REQ-022 Close SHALL occur the cycle after the final transfer: pkt_done_o=1, pkt_ok_o=ok, and either pkt_count_o or err_count_o incremented by 1.
REQ-023 Both counters SHALL saturate at 16'hFFFF.
REQ-024 A cycle without a transfer SHALL leave all state unchanged; stall_i mid-packet is legal and SHALL not cause an error.

Reset
REQ-025 While reset=0: state=IDLE, rd_dst_rdy_o=0, pkt_done_o=0, pkt_ok_o=0, counters=0, word_idx=0, bad=0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet with no count update; after release the receiver SHALL wait for SOF.
REQ-027 Deassertion SHALL be synchronized by the top-level reset logic; no internal synchronizer.

Structure
REQ-028 Flag bit positions (SOF=0, EOF=1, OCC=[3:2]) and state encodings SHALL live in the shared package, common with packet_sender.
REQ-029 SHALL be a single module; the saturating 16-bit counter MAY be the sub-module sat_counter16, instantiated twice.

Verification
REQ-030 packet_size_i=16, packet_sender drives the input, no stall -> one pkt_done_o with pkt_ok_o=1, pkt_count_o=1, err_count_o=0.
REQ-031 Same packet with stall_i=1 for 10 cycles after word 5 -> rd_dst_rdy_o=0 during stall, pkt_ok_o=1, pkt_count_o=1.
REQ-032 16-word packet with word 7 data=32'hDEAD -> pkt_ok_o=0, err_count_o=1.
REQ-033 Packet with EOF on word 12 while packet_size_i=16 -> pkt_ok_o=0; EOF word with occupancy=2 -> pkt_ok_o=0.
REQ-034 3 words without SOF then a good packet -> err_count_o=1, then pkt_count_o=1; SOF at word 8 of a packet -> first packet counted bad, second judged normally.
REQ-035 reset pulsed low at word 6 -> outputs zero asynchronously; the next full packet gives pkt_count_o=1.
